// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler
//   Clocked tank supervisor and round-robin irrigation scheduler.
//   - The tank inlet valve uses hysteresis on the mid/high sensors and is
//     forced shut while the sensors disagree with each other.
//   - A sensor inconsistency must persist for ERR_PERSIST ticks before
//     `error` sets, and the sensors must be consistent for ERR_PERSIST ticks
//     before it clears.
//   - One zone runs at a time. Each run uses either the sprinkler (asp) or
//     the dripper (got) for a fixed number of ticks, then waits GAP_TICKS
//     ticks before the next run.
//   - `alarme` is sticky and is cleared by alarm_ack.
//
// Optional build macro: IRRIG_SOAK_EN adds a per-zone soak lockout of
//   SOAK_TICKS ticks after each run that completes normally.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   tick            one-cycle time-base strobe; all timers count ticks
//   low, mid, high  tank level sensors
//   Us[ZONES]       per-zone soil-dry request
//   Ua, T           air-dry and high-temperature flags (select run mode)
//   alarm_ack       acknowledge for the sticky alarm
//   watter_supply   tank inlet valve
//   error           debounced sensor-inconsistency flag
//   alarme          sticky alarm
//   asp, got        per-zone sprinkler / dripper valves (at most one bit set)
//   busy            a run or inter-run gap is in progress
//   zone_idx        active zone, or the last zone that was granted
module irrigation_zone_scheduler #(
  parameter int ZONES          = 4,
  parameter int TIMER_W        = 8,
  parameter int SPRINKLE_TICKS = 10,
  parameter int DRIP_TICKS     = 30,
  parameter int GAP_TICKS      = 2,
  parameter int ERR_PERSIST    = 3,
  parameter int SOAK_TICKS     = 20,
  localparam int ZW            = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             low,
  input  logic             mid,
  input  logic             high,
  input  logic [ZONES-1:0] Us,
  input  logic             Ua,
  input  logic             T,
  input  logic             alarm_ack,
  output logic             watter_supply,
  output logic             error,
  output logic             alarme,
  output logic [ZONES-1:0] asp,
  output logic [ZONES-1:0] got,
  output logic             busy,
  output logic [ZW-1:0]    zone_idx
);

  localparam int EW = $clog2(ERR_PERSIST + 1) + 1;
  localparam logic [TIMER_W-1:0] SPR_LOAD  = TIMER_W'(SPRINKLE_TICKS);
  localparam logic [TIMER_W-1:0] DRIP_LOAD = TIMER_W'(DRIP_TICKS);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t             state;
  logic [ZW-1:0]      ptr;
  logic [TIMER_W-1:0] timer;
  logic [EW-1:0]      err_cnt;

  // ---------------------------------------------------------------------
  // Sensor-consistency debounce. The counter tracks how many consecutive
  // ticks the sampled pattern has disagreed with the current error state.
  // ---------------------------------------------------------------------
  logic          invalid;
  logic          error_nxt;
  logic [EW-1:0] err_cnt_inc;
  logic [EW-1:0] err_cnt_nxt;

  assign invalid     = (mid & ~low) | (high & ~mid);
  assign err_cnt_inc = err_cnt + EW'(1);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    error_nxt   = error;
    err_cnt_nxt = err_cnt;
    if (tick) begin
      if (invalid != error) begin
        if (err_cnt_inc >= EW'(ERR_PERSIST)) begin
          error_nxt   = invalid;
          err_cnt_nxt = '0;
        end else begin
          err_cnt_nxt = err_cnt_inc;
        end
      end else begin
        err_cnt_nxt = '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Run control helpers
  // ---------------------------------------------------------------------
  logic abort;
  logic run_done;
  logic gap_done;
  logic run_ok_done;

  assign abort       = (state == S_RUN) & (~low | error);
  // A zero-length duration still spends one cycle in RUN before leaving.
  assign run_done    = (timer == '0) | (tick & (timer == TIMER_W'(1)));
  assign gap_done    = run_done;
  assign run_ok_done = (state == S_RUN) & ~abort & run_done;

  // ---------------------------------------------------------------------
  // Optional soak lockout
  // ---------------------------------------------------------------------
  logic [ZONES-1:0] soak_lock;

`ifdef IRRIG_SOAK_EN
  localparam logic [TIMER_W-1:0] SOAK_LOAD = TIMER_W'(SOAK_TICKS);
  logic [TIMER_W-1:0] soak_cnt [ZONES];

  // NOTE: the lockout counters are reset explicitly because eligibility
  // reads them on the very first cycle after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ZONES; i++) begin
      if (rst) begin
        soak_cnt[i] <= '0;
      end else if (run_ok_done && (zone_idx == ZW'(i))) begin
        soak_cnt[i] <= SOAK_LOAD;
      end else if (tick && (soak_cnt[i] != '0)) begin
        soak_cnt[i] <= soak_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    soak_lock = '0;
    for (int i = 0; i < ZONES; i++) soak_lock[i] = (soak_cnt[i] != '0);
  end
`else
  // The lockout length stays referenced so the parameter list is the same
  // in both builds.
  logic [31:0] soak_unused;
  assign soak_unused = 32'(SOAK_TICKS);
  assign soak_lock   = '0;
`endif

  // ---------------------------------------------------------------------
  // Round-robin grant: first eligible zone at or above the pointer, wrapping.
  // ---------------------------------------------------------------------
  logic [ZONES-1:0] eligible;
  logic [ZONES-1:0] grant_oh;
  logic [ZW-1:0]    grant;
  logic [ZW-1:0]    cand;
  logic [ZW-1:0]    next_ptr;
  logic             any_elig;
  logic             spr_cond;
  logic             alarm_set;

  assign eligible = Us & {ZONES{low & ~error}} & ~soak_lock;

  always_comb begin
    grant    = '0;
    cand     = '0;
    any_elig = 1'b0;
    for (int k = 0; k < ZONES; k++) begin
      cand = ZW'((int'(ptr) + k) % ZONES);
      if (!any_elig && eligible[cand]) begin
        grant    = cand;
        any_elig = 1'b1;
      end
    end
  end

  assign grant_oh  = ZONES'(1) << grant;
  assign next_ptr  = (grant == ZW'(ZONES - 1)) ? '0 : grant + ZW'(1);
  assign spr_cond  = Ua & ~T & mid;
  assign alarm_set = abort | (error_nxt & ~error) |
                     ((state == S_IDLE) & (|Us) & ~low);

  // ---------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      timer         <= '0;
      err_cnt       <= '0;
      error         <= 1'b0;
      watter_supply <= 1'b0;
      alarme        <= 1'b0;
      asp           <= '0;
      got           <= '0;
      busy          <= 1'b0;
      zone_idx      <= '0;
    end else begin
      err_cnt <= err_cnt_nxt;
      error   <= error_nxt;

      // Inlet hysteresis: open below mid, close at high, hold in between.
      if (error_nxt || high) watter_supply <= 1'b0;
      else if (!mid)         watter_supply <= 1'b1;

      // Set has priority over acknowledge.
      if (alarm_set)      alarme <= 1'b1;
      else if (alarm_ack) alarme <= 1'b0;

      case (state)
        S_IDLE: begin
          if (any_elig) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            zone_idx <= grant;
            ptr      <= next_ptr;
            if (spr_cond) begin
              asp   <= grant_oh;
              timer <= SPR_LOAD;
            end else begin
              got   <= grant_oh;
              timer <= DRIP_LOAD;
            end
          end
        end
        S_RUN: begin
          // Abort and normal expiry both close the valve and enter GAP.
          if (abort || run_done) begin
            state <= S_GAP;
            asp   <= '0;
            got   <= '0;
            timer <= GAP_LOAD;
          end else if (tick) begin
            timer <= timer - 1'b1;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Testbench for irrigation_zone_scheduler.
// A reference model predicts all outputs from the inputs seen at each clock
// edge and pushes them into a queue; an independent monitor pops and compares
// against the DUT half a cycle later. Stimulus is a directed walk through the
// main scenarios followed by randomized tank levels, requests and resets.
// Define IRRIG_SOAK_EN for both the RTL and this file to exercise the lockout.
module tb_irrigation_zone_scheduler;

  localparam int ZONES = 4;
  localparam int SPR   = 3;
  localparam int DRIP  = 5;
  localparam int GAP   = 2;
  localparam int EP    = 2;
  localparam int SOAK  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic             low, mid, high;
  logic [ZONES-1:0] Us;
  logic             Ua, T, alarm_ack;
  logic             watter_supply, error, alarme, busy;
  logic [ZONES-1:0] asp, got;
  logic [1:0]       zone_idx;

  irrigation_zone_scheduler #(
    .ZONES(ZONES), .TIMER_W(8), .SPRINKLE_TICKS(SPR), .DRIP_TICKS(DRIP),
    .GAP_TICKS(GAP), .ERR_PERSIST(EP), .SOAK_TICKS(SOAK)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .low(low), .mid(mid), .high(high),
    .Us(Us), .Ua(Ua), .T(T), .alarm_ack(alarm_ack),
    .watter_supply(watter_supply), .error(error), .alarme(alarme),
    .asp(asp), .got(got), .busy(busy), .zone_idx(zone_idx)
  );

  always #5 clk = ~clk;

  // tick every 4 clocks, driven just after the edge like all other inputs
  int tick_div = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick     = (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
    end
  end

  typedef struct packed {
    logic       ws;
    logic       err;
    logic       alarm;
    logic [3:0] asp;
    logic [3:0] got;
    logic       busy;
    logic [1:0] zidx;
  } out_t;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- reference model ----------------
  // phase: 0 = waiting, 1 = watering, 2 = pause between runs
  int m_phase, m_left, m_ptr, m_zone, m_errcnt;
  int m_soak[ZONES];
  bit m_err, m_ws, m_alarm, m_spr;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_ptr = 0; m_zone = 0; m_errcnt = 0;
    m_err = 0; m_ws = 0; m_alarm = 0; m_spr = 0;
    for (int i = 0; i < ZONES; i++) m_soak[i] = 0;
  endtask

  always @(posedge clk) begin
    out_t       e;
    bit         bad, new_err, aset, finished_ok;
    int         g, z;
    logic [3:0] oh;
    if (rst) begin
      model_reset();
    end else begin
      bad         = (mid && !low) || (high && !mid);
      new_err     = m_err;
      aset        = 0;
      finished_ok = 0;
      g           = -1;
      if (tick) begin
        if (bad != m_err) begin
          m_errcnt++;
          if (m_errcnt >= EP) begin
            new_err  = bad;
            m_errcnt = 0;
          end
        end else begin
          m_errcnt = 0;
        end
      end
      if (new_err && !m_err) aset = 1;

      if (m_phase == 0) begin
        if (Us != 0 && !low) aset = 1;
        for (int k = 0; k < ZONES; k++) begin
          z = (m_ptr + k) % ZONES;
          if (g < 0 && Us[z] && low && !m_err && m_soak[z] == 0) g = z;
        end
        if (g >= 0) begin
          m_phase = 1;
          m_zone  = g;
          m_ptr   = (g + 1) % ZONES;
          m_spr   = Ua && !T && mid;
          m_left  = m_spr ? SPR : DRIP;
        end
      end else if (m_phase == 1) begin
        if (!low || m_err) begin
          aset    = 1;
          m_phase = 2;
          m_left  = GAP;
        end else begin
          if (tick) m_left--;
          if (m_left <= 0) begin
            finished_ok = 1;
            m_phase     = 2;
            m_left      = GAP;
          end
        end
      end else begin
        if (tick) m_left--;
        if (m_left <= 0) m_phase = 0;
      end

`ifdef IRRIG_SOAK_EN
      for (int i = 0; i < ZONES; i++) if (tick && m_soak[i] > 0) m_soak[i]--;
      if (finished_ok) m_soak[m_zone] = SOAK;
`endif

      if (new_err || high) m_ws = 0;
      else if (!mid)       m_ws = 1;
      if (aset)           m_alarm = 1;
      else if (alarm_ack) m_alarm = 0;
      m_err = new_err;
    end

    oh      = 4'b0001 << m_zone;
    e.ws    = m_ws;
    e.err   = m_err;
    e.alarm = m_alarm;
    e.asp   = (m_phase == 1 && m_spr)  ? oh : 4'b0000;
    e.got   = (m_phase == 1 && !m_spr) ? oh : 4'b0000;
    e.busy  = (m_phase != 0);
    e.zidx  = 2'(m_zone);
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    out_t e, a;
    a = '{ws: watter_supply, err: error, alarm: alarme, asp: asp, got: got,
          busy: busy, zidx: zone_idx};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty @%0t: no expected entry for actual %h", $time, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: actual ws=%b err=%b alarm=%b asp=%b got=%b busy=%b zone=%0d | required ws=%b err=%b alarm=%b asp=%b got=%b busy=%b zone=%0d",
                 $time, a.ws, a.err, a.alarm, a.asp, a.got, a.busy, a.zidx,
                 e.ws, e.err, e.alarm, e.asp, e.got, e.busy, e.zidx);
      end
    end
    n_checks++;
    if ($countones({asp, got}) > 1) begin
      n_fail++;
      $display("FAIL valve_exclusive @%0t: actual asp=%b got=%b, required at most one valve open",
               $time, asp, got);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_level(input int lvl);
    low  = (lvl >= 1);
    mid  = (lvl >= 2);
    high = (lvl >= 3);
  endtask

  int lvl, r, hold;

  initial begin
    rst = 1'b1; low = 0; mid = 0; high = 0; Us = '0; Ua = 0; T = 0; alarm_ack = 0;
    cycles(3);
    rst = 1'b0;

    // fill hysteresis
    set_level(1);          cycles(8);
    set_level(2);          cycles(8);
    set_level(3);          cycles(8);
    set_level(2);          cycles(8);
    set_level(1);          cycles(8);

    // error debounce: one invalid tick, then two, then valid, then ack
    low = 0; mid = 1; high = 0; cycles(4);
    set_level(1);               cycles(8);
    low = 0; mid = 1; high = 0; cycles(12);
    set_level(2);               cycles(12);
    alarm_ack = 1;              cycles(1);
    alarm_ack = 0;              cycles(2);

    // round robin, sprinkler mode
    set_level(2); Us = 4'b1010; Ua = 1; T = 0; cycles(90);

    // dripper mode
    Us = 4'b0001; T = 1; cycles(60);
    Us = 4'b0000; cycles(12);

    // abort mid-run, then ack while a request is pending on an empty tank
    Us = 4'b0100; T = 0; cycles(6);
    set_level(0); cycles(4);
    alarm_ack = 1; cycles(20);
    Us = 4'b0000; cycles(2);
    alarm_ack = 0; cycles(2);
    alarm_ack = 1; cycles(1);
    alarm_ack = 0;

    // reset while zone 2 is watering, then search restarts at zone 0
    set_level(2); Us = 4'b0100; cycles(20);
    Us = 4'b0101; cycles(6);
    rst = 1'b1; cycles(1);
    rst = 1'b0; cycles(80);

    // randomized
    lvl = 2;
    for (int blk = 0; blk < 150; blk++) begin
      r = $urandom_range(0, 9);
      if (r < 2 && lvl < 3) lvl++;
      else if (r < 4 && lvl > 0) lvl--;
      set_level(lvl);
      if (r == 9) begin
        if ($urandom_range(0, 1) == 1) begin low = 0; mid = 1; high = 0; end
        else begin low = 1; mid = 0; high = 1; end
      end
      if ($urandom_range(0, 2) == 0) Us = 4'($urandom_range(0, 15));
      Ua        = 1'($urandom_range(0, 1));
      T         = 1'($urandom_range(0, 1));
      alarm_ack = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 40) == 0);
      if (rst) begin
        cycles(2);
        rst = 1'b0;
      end
      hold = $urandom_range(4, 30);
      cycles(hold);
    end

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
